// File: rtl/unsigned_divider_16by8_seq_if.sv
// Handshake/operand bundle for the 16-by-8 unsigned sequential divider.
// The master side supplies operands and consumes results; the slave side is the divider.
interface unsigned_divider_16by8_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] z;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  x;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;

    modport master (
        output in_valid, z, y, out_ready,
        input  in_ready, out_valid, x, r, ovf, dz
    );

    modport slave (
        input  in_valid, z, y, out_ready,
        output in_ready, out_valid, x, r, ovf, dz
    );
endinterface

// File: rtl/unsigned_divider_16by8_seq.sv
// Sequential restoring divider: 16-bit dividend z, 8-bit divisor y,
// 8-bit quotient x and 8-bit remainder r, one quotient bit per cycle.
// Divide-by-zero and quotient overflow are detected at accept time and
// answered in a single cycle without entering the iterative loop.
// Build option: define UDIV16X8_REM_OUT_EN to drive the remainder on r;
// when it is undefined r is tied to zero and everything else is unchanged.
module unsigned_divider_16by8_seq (
    input  logic                               clk,
    input  logic                               rst,
    unsigned_divider_16by8_seq_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    // Partial remainder is kept 9 bits wide so the shifted value T fits.
    logic [8:0]  p_r;
    logic [8:0]  p_nxt_s;
    logic [7:0]  q_r;
    logic [7:0]  q_nxt_s;
    logic [7:0]  d_r;
    logic [7:0]  d_nxt_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_nxt_s;

    logic [7:0]  x_r;
    logic [7:0]  x_nxt_s;
    logic [7:0]  rem_r;
    logic [7:0]  rem_nxt_s;
    logic        ovf_r;
    logic        ovf_nxt_s;
    logic        dz_r;
    logic        dz_nxt_s;

    logic        accept_s;
    logic [16:0] step_s;

    // One restoring-division step: shift in the next dividend bit, try a
    // subtract, and shift the resulting quotient bit into Q.
    // Result packing is {P_new[8:0], Q_new[7:0]}.
    function automatic logic [16:0] div_step(
        input logic [8:0] p,
        input logic [7:0] q,
        input logic [7:0] d
    );
        logic [8:0] t;
        logic       b;
        logic [8:0] p_new;
        logic [7:0] q_new;
        t     = {p[7:0], q[7]};
        b     = (t >= {1'b0, d});
        p_new = b ? (t - {1'b0, d}) : t;
        q_new = {q[6:0], b};
        return {p_new, q_new};
    endfunction

    // Remainder source selection; collapses to zero when the remainder
    // output is not built.
    function automatic logic [7:0] rem_sel(input logic [7:0] v);
`ifdef UDIV16X8_REM_OUT_EN
        return v;
`else
        return (v & 8'h00);
`endif
    endfunction

    assign accept_s = bus.in_valid && (state_r == IDLE);
    assign step_s   = div_step(p_r, q_r, d_r);

    // Next-state and datapath update: accept/fast-path decode in IDLE,
    // iteration in CALC, hold until the consumer takes the result in DONE.
    always_comb begin
        state_nxt_s = state_r;
        p_nxt_s     = p_r;
        q_nxt_s     = q_r;
        d_nxt_s     = d_r;
        cnt_nxt_s   = cnt_r;
        x_nxt_s     = x_r;
        rem_nxt_s   = rem_r;
        ovf_nxt_s   = ovf_r;
        dz_nxt_s    = dz_r;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (bus.y == 8'h00) begin
                        // Divide by zero: saturate quotient, pass low byte through.
                        x_nxt_s     = 8'hFF;
                        rem_nxt_s   = rem_sel(bus.z[7:0]);
                        ovf_nxt_s   = 1'b0;
                        dz_nxt_s    = 1'b1;
                        state_nxt_s = DONE;
                    end else if (bus.z[15:8] >= bus.y) begin
                        // Quotient would need more than 8 bits.
                        x_nxt_s     = 8'hFF;
                        rem_nxt_s   = 8'h00;
                        ovf_nxt_s   = 1'b1;
                        dz_nxt_s    = 1'b0;
                        state_nxt_s = DONE;
                    end else begin
                        p_nxt_s     = {1'b0, bus.z[15:8]};
                        q_nxt_s     = bus.z[7:0];
                        d_nxt_s     = bus.y;
                        cnt_nxt_s   = 3'd0;
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            CALC: begin
                p_nxt_s   = step_s[16:8];
                q_nxt_s   = step_s[7:0];
                cnt_nxt_s = cnt_r + 3'd1;
                if (cnt_r == 3'd7) begin
                    // Eighth step: publish the final quotient and remainder.
                    x_nxt_s     = step_s[7:0];
                    rem_nxt_s   = rem_sel(step_s[15:8]);
                    ovf_nxt_s   = 1'b0;
                    dz_nxt_s    = 1'b0;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and discards
    // any result that is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            p_r     <= 9'd0;
            q_r     <= 8'd0;
            d_r     <= 8'd0;
            cnt_r   <= 3'd0;
            x_r     <= 8'd0;
            rem_r   <= 8'd0;
            ovf_r   <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            p_r     <= p_nxt_s;
            q_r     <= q_nxt_s;
            d_r     <= d_nxt_s;
            cnt_r   <= cnt_nxt_s;
            x_r     <= x_nxt_s;
            rem_r   <= rem_nxt_s;
            ovf_r   <= ovf_nxt_s;
            dz_r    <= dz_nxt_s;
        end
    end

    // Handshake flags decode straight from the state register; result
    // fields come straight from their registers.
    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.x         = x_r;
    assign bus.r         = rem_r;
    assign bus.ovf       = ovf_r;
    assign bus.dz        = dz_r;

endmodule

// File: doc/unsigned_divider_16by8_seq.md
UNSIGNED_DIVIDER_16BY8_SEQ -- requirements
Module: unsigned_divider_16by8_seq

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at a 16-bit dividend, an 8-bit divisor, an 8-bit quotient and an 8-bit remainder.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operands z, y are valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 z  input  16  unsigned dividend (the product side of z = x*y).
REQ-007 y  input  8  unsigned divisor.
REQ-008 out_valid  output  1  result fields are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 x  output  8  unsigned quotient.
REQ-011 r  output  8  unsigned remainder.
REQ-012 ovf  output  1  true quotient does not fit in 8 bits.
REQ-013 dz  output  1  divide by zero.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-015 in_ready SHALL be 1 exactly in IDLE; a transfer occurs on an edge with in_valid=1 and in_ready=1.
REQ-016 On a transfer with y=0, the block SHALL go to DONE with dz=1, ovf=0, x=8'hFF, r=z[7:0].
REQ-017 On a transfer with y!=0 and z[15:8]>=y, the block SHALL go to DONE with ovf=1, dz=0, x=8'hFF, r=8'h00.
REQ-018 On any other transfer, the block SHALL latch P=z[15:8] (9-bit partial remainder), Q=z[7:0] and y, clear a 3-bit counter, and enter CALC.
REQ-019 Each CALC cycle SHALL compute T={P[7:0],Q[7]} and set b=(T>=y), P=b?T-y:T, Q={Q[6:0],b}.
REQ-020 After the 8th CALC cycle (counter wrapping from 7), the block SHALL enter DONE with x=Q, r=P[7:0], ovf=0, dz=0.
REQ-021 Normal-path latency SHALL be 9 edges from the transfer edge to out_valid=1; the fast paths (REQ-016, REQ-017) SHALL take 1 edge.
REQ-022 out_valid SHALL be 1 exactly in DONE, and x, r, ovf and dz SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 In DONE with out_ready=1, the block SHALL return to IDLE on that edge; no new operand is accepted on the same edge (no bypass).
REQ-024 in_valid and operand changes during CALC or DONE SHALL be ignored.
REQ-025 For all non-fault inputs, the results SHALL satisfy z = x*y + r with r < y.

Reset
REQ-026 While rst=1 at an edge, the state SHALL go to IDLE, and x, r, ovf, dz, out_valid, the counter, P and Q SHALL all clear to 0.
REQ-027 Reset SHALL take priority over any transfer or handshake on the same edge, including mid-CALC and in DONE; any in-flight result is discarded.
REQ-028 in_ready SHALL be 1 on the first edge after rst deasserts.

Configuration
REQ-029 The macro UDIV16X8_REM_OUT_EN SHALL select whether the remainder is output.
REQ-030 With UDIV16X8_REM_OUT_EN defined, r SHALL be driven per REQ-016, REQ-017 and REQ-020.
REQ-031 Without UDIV16X8_REM_OUT_EN, r SHALL be constant 0; the port remains; x, ovf, dz and timing are unchanged.

Verification
REQ-032 z=16'd1000, y=8'd10, out_ready=1 -> out_valid 9 edges after transfer, x=100, r=0, ovf=0, dz=0.
REQ-033 z=16'd12345, y=8'd123 -> x=100, r=45; without UDIV16X8_REM_OUT_EN -> r=0.
REQ-034 z=16'h1000, y=8'h10 -> after 1 edge, ovf=1, x=8'hFF, r=0; y=0, z=16'h00AB -> dz=1, x=8'hFF, r=8'hAB.
REQ-035 z=16'd65025, y=8'd255, out_ready held 0 for 5 cycles -> x=255 and r=0 held stable with out_valid=1 throughout; returns to IDLE on the edge where out_ready=1.
REQ-036 rst=1 at the 4th CALC cycle -> next cycle IDLE, out_valid=0, in_ready=1; a following transfer of z=16'd99, y=8'd7 -> x=14, r=1.
REQ-037 Random sweep of 10^5 legal (z, y) pairs against the reference model z/y, z%y with random in_valid/out_ready stalls -> zero mismatches and no lost or duplicated results.
